param_booth_multiplier: RTL

PARAM_BOOTH_MULTIPLIER -- requirements
Module: param_booth_multiplier

---
 rtl/mult_pkg.sv | 31 +++
 rtl/booth_pp_sel.sv | 44 ++++
 rtl/param_booth_multiplier.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// Module  : mult_pkg
// Brief   : Shared types and helpers for the radix-4 Booth multiplier.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_POS1 = 3'd1,
        BD_POS2 = 3'd2,
        BD_NEG1 = 3'd3,
        BD_NEG2 = 3'd4
    } booth_digit_e;

    // Radix-4 digits needed to cover a (width+2)-bit extended multiplier.
    function automatic int num_digits(input int width);
        return width / 2 + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_pp_sel.sv
// ============================================================================
// Module  : booth_pp_sel
// Brief   : Radix-4 Booth digit decode and partial-product select.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_pp_sel
    import mult_pkg::*;
#(
    parameter int PP_W = 64
) (
    input  logic [2:0]      i_bits,
    input  logic [PP_W-1:0] i_mcand,
    output logic [PP_W-1:0] o_pp
);

    booth_digit_e w_digit;

    always_comb begin
        w_digit = BD_ZERO;
        case (i_bits)
            3'b001, 3'b010: w_digit = BD_POS1;
            3'b011:         w_digit = BD_POS2;
            3'b100:         w_digit = BD_NEG2;
            3'b101, 3'b110: w_digit = BD_NEG1;
            default:        w_digit = BD_ZERO;
        endcase
    end

    always_comb begin
        o_pp = '0;
        case (w_digit)
            BD_POS1: o_pp = i_mcand;
            BD_POS2: o_pp = i_mcand << 1;
            BD_NEG1: o_pp = ~i_mcand + PP_W'(1);
            BD_NEG2: o_pp = ~(i_mcand << 1) + PP_W'(1);
            default: o_pp = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/param_booth_multiplier.sv
// ============================================================================
// Module  : param_booth_multiplier
// Brief   : Sequential radix-4 Booth multiplier, one digit per cycle.
//           Define MULT_EARLY_TERM_EN to stop once remaining digits are zero.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               signed_mode,
    input  logic               op_start,
    input  logic               op_clear,
    output logic               op_busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result
);

    localparam int N       = num_digits(WIDTH);
    localparam int CW      = $clog2(N);
    localparam int MW      = WIDTH + 3;
    localparam int PW      = 2 * WIDTH;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    mult_state_e   state_q, state_d;
    // Extended multiplier with the Booth guard bit appended at bit 0.
    logic [MW-1:0] mplr_q, mplr_d;
    // Multiplicand pre-shifted by 2*digit so every partial product lands aligned.
    logic [PW-1:0] mcand_q, mcand_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [PW-1:0] pp;
    logic [MW-1:0] mplr_shift;
    logic          last_digit;

    booth_pp_sel #(
        .PP_W (PW)
    ) u_pp_sel (
        .i_bits  (mplr_q[2:0]),
        .i_mcand (mcand_q),
        .o_pp    (pp)
    );

    assign mplr_shift = {{2{mplr_q[MW-1]}}, mplr_q[MW-1:2]};

`ifdef MULT_EARLY_TERM_EN
    assign last_digit = (cnt_q == C_LAST) || (mplr_shift == '0) || (&mplr_shift);
`else
    assign last_digit = (cnt_q == C_LAST);
`endif

    always_comb begin
        state_d = state_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    mplr_d  = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier, 1'b0};
                    mcand_d = {{WIDTH{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                acc_d   = acc_q + pp;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_shift;
                cnt_d   = cnt_q + CW'(1);
                if (last_digit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (op_clear) begin
            state_d = ST_IDLE;
            mplr_d  = '0;
            mcand_d = '0;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mplr_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_busy = (state_q == ST_EXEC);
    assign op_done = (state_q == ST_DONE);
    assign result  = op_done ? acc_q : '0;

endmodule

`default_nettype wire
